// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and byte/word helpers for the AES-128
// key-schedule sequencer.
package aes_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int KEY_W      = 128;
  localparam int WORD_W     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // {b0,b1,b2,b3} -> {b1,b2,b3,b0}
  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[WORD_W-9:0], w[WORD_W-1 -: 8]};
  endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box, NUM bytes in parallel.
// Ports:
//   data_in  [8*NUM-1:0]  input bytes, byte 0 at the MSB end
//   data_out [8*NUM-1:0]  substituted bytes, same ordering
module sbox #(
  parameter int NUM = 4
) (
  input  logic [8*NUM-1:0] data_in,
  output logic [8*NUM-1:0] data_out
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar i = 0; i < NUM; i++) begin : g_byte
    assign data_out[8*i +: 8] = SBOX_TABLE[data_in[8*i +: 8]];
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key-schedule sequencer. On a start pulse in IDLE the cipher key is
// loaded as round key 0; each accepted handshake advances to the next round
// key, computed combinationally from the registered key. After round key 10
// transfers the block returns to IDLE and pulses done.
// Ports:
//   clk       clock, all state on rising edge
//   rst_n     synchronous active-low reset
//   start     begin expansion of key_in (IDLE only)
//   key_in    cipher key, byte 0 at [127:120]
//   rk_valid  rk_out/rk_idx hold a round key
//   rk_ready  consumer accepts the current round key
//   rk_idx    round index of rk_out, 0..10
//   rk_out    round key, w0 at [127:96], w3 at [31:0]
//   busy      expansion in progress
//   done      one-cycle pulse after the last round key transfers
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int ROUNDS = AES_ROUNDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out,
  output logic             busy,
  output logic             done
);

  if (ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes_key_expand: only ROUNDS=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] rk_out_q, rk_out_d;
  logic [3:0]       rk_idx_q, rk_idx_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             rk_valid_q, rk_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] sub_word, t_word;
  logic [WORD_W-1:0] nw0, nw1, nw2, nw3;
  logic              xfer;

  assign {w0, w1, w2, w3} = rk_out_q;

  sbox #(.NUM(4)) u_sbox (
    .data_in  (rot_word(w3)),
    .data_out (sub_word)
  );

  assign t_word = sub_word ^ {rcon_q, 24'h0};
  assign nw0    = w0 ^ t_word;
  assign nw1    = w1 ^ nw0;
  assign nw2    = w2 ^ nw1;
  assign nw3    = w3 ^ nw2;

  assign xfer = rk_valid_q & rk_ready;

  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_out_d   = key_in;
          rk_idx_d   = 4'd0;
          rcon_d     = 8'h01;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (rk_idx_q == LAST_IDX) begin
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            rk_out_d = {nw0, nw1, nw2, nw3};
            rk_idx_d = rk_idx_q + 4'd1;
            rcon_d   = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rk_out_q   <= '0;
      rk_idx_q   <= 4'd0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;
  assign rk_out   = rk_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

  // FIPS-197 A.1 round keys 0..10
  localparam logic [127:0] A1 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_idx   (rk_idx),
    .rk_out   (rk_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic [3:0] idx,
                         input logic b, input logic d);
    chk({tag, ".valid"}, 128'(rk_valid), 128'(v));
    chk({tag, ".idx"},   128'(rk_idx),   128'(idx));
    chk({tag, ".busy"},  128'(busy),     128'(b));
    chk({tag, ".done"},  128'(done),     128'(d));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    tick();
    tick();
    chk_ctl("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    chk("reset.rk_out", rk_out, '0);

    // FIPS-197 A.1 full expansion, ready always high
    rst_n    = 1'b1;
    rk_ready = 1'b1;
    start    = 1'b1;
    key_in   = KEY_A1;
    tick();
    start  = 1'b0;
    key_in = '0;
    for (int i = 0; i <= 10; i++) begin
      chk_ctl($sformatf("a1.c%0d", i + 1), 1'b1, 4'(i), 1'b1, 1'b0);
      chk($sformatf("a1.rk%0d", i), rk_out, A1[i]);
      tick();
    end
    chk_ctl("a1.done_cycle", 1'b0, 4'd10, 1'b0, 1'b1);
    tick();
    chk("a1.done_clear", 128'(done), 128'd0);

    // Zero key; restart in the done cycle with the A.1 key
    start  = 1'b1;
    key_in = '0;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("zero.idx%0d", i), 128'(rk_idx), 128'(i));
      if (i == 1) chk("zero.rk1", rk_out, 128'h62636363626363636263636362636363);
      if (i == 10) chk("zero.rk10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      tick();
    end
    chk("zero.done", 128'(done), 128'd1);
    start  = 1'b1;
    key_in = KEY_A1;
    tick();
    start = 1'b0;
    chk_ctl("restart", 1'b1, 4'd0, 1'b1, 1'b0);
    chk("restart.rk0", rk_out, KEY_A1);

    // Advance to idx 3, pulse start with another key: must be ignored
    tick();
    tick();
    tick();
    chk("ign.idx3", 128'(rk_idx), 128'd3);
    start  = 1'b1;
    key_in = KEY_C1;
    tick();
    start  = 1'b0;
    key_in = '0;
    chk_ctl("ign.idx4", 1'b1, 4'd4, 1'b1, 1'b0);
    chk("ign.rk4", rk_out, A1[4]);

    // Backpressure at idx 4 for three cycles
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctl($sformatf("bp.c%0d", i), 1'b1, 4'd4, 1'b1, 1'b0);
      chk($sformatf("bp.rk4.c%0d", i), rk_out, A1[4]);
    end
    rk_ready = 1'b1;
    tick();
    chk("bp.idx5", 128'(rk_idx), 128'd5);
    chk("bp.rk5", rk_out, A1[5]);
    tick();
    chk("pre_rst.rk6", rk_out, A1[6]);

    // Reset mid-expansion at idx 6
    rst_n = 1'b0;
    tick();
    chk_ctl("midrst", 1'b0, 4'd0, 1'b0, 1'b0);
    chk("midrst.rk_out", rk_out, '0);
    rst_n  = 1'b1;
    start  = 1'b1;
    key_in = KEY_C1;
    tick();
    start  = 1'b0;
    key_in = '0;
    chk_ctl("post_rst", 1'b1, 4'd0, 1'b1, 1'b0);
    chk("post_rst.rk0", rk_out, KEY_C1);
    tick();
    chk("post_rst.rk1", rk_out, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    for (int i = 2; i <= 10; i++) tick();
    chk("post_rst.idx10", 128'(rk_idx), 128'd10);
    chk("post_rst.rk10", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    tick();
    chk_ctl("post_rst.done", 1'b0, 4'd10, 1'b0, 1'b1);

    // ready with nothing valid must not disturb anything
    tick();
    chk_ctl("idle_ready", 1'b0, 4'd10, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
